i2cs_regif: RTL and testbench

I2C slave front-end that turns I2C bus transactions into single-cycle host register accesses on `reg_we`/`reg_addr`/`reg_wdata`/`reg_rdata`. It is the responder side of the register host interface and sits between the chip pads and the paged register top on the `i2csf_clk` domain. It supports write-with-auto-increment, and read via repeated START, with auto-increment.

---
 rtl/i2cs_pkg.sv | 26 ++
 rtl/i2cs_line_cond.sv | 55 +++++
 rtl/i2cs_regif.sv | 166 ++++++++++++++++
 tb/tb_i2cs_regif.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2cs_pkg.sv
// Shared constants for the I2C slave register front-end: state codes,
// default device address and bit-counter width.
package i2cs_pkg;

  localparam logic [6:0] DEV_ID_DEF = 7'h3C;
  localparam int         CNT_W      = 3;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_DEV       = 4'd1;
  localparam state_t ST_DEV_ACK   = 4'd2;
  localparam state_t ST_ADDR      = 4'd3;
  localparam state_t ST_ADDR_ACK  = 4'd4;
  localparam state_t ST_WDATA     = 4'd5;
  localparam state_t ST_WDATA_ACK = 4'd6;
  localparam state_t ST_RD_LOAD   = 4'd7;
  localparam state_t ST_RDATA     = 4'd8;
  localparam state_t ST_RD_MACK   = 4'd9;
  localparam state_t ST_WAIT_STOP = 4'd10;

  function automatic logic [7:0] addr_inc(input logic [7:0] a);
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/i2cs_line_cond.sv
// Pad conditioning for one I2C line: 2-FF synchronizer, optional glitch
// filter (I2CS_GLITCH_FLT_EN) and rise/fall pulse generation.
module i2cs_line_cond #(
  parameter int FLT_LEN = 3
) (
  input  logic i2csf_clk,
  input  logic i2csf_rst_n,
  input  logic pad,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       flt;
  logic       prev;

  // Reset to 1 so an idle (pulled-up) bus produces no edge after reset.
  always_ff @(posedge i2csf_clk or negedge i2csf_rst_n) begin
    if (!i2csf_rst_n) sync <= 2'b11;
    else              sync <= {sync[0], pad};
  end

`ifdef I2CS_GLITCH_FLT_EN
  localparam int FW = $clog2(FLT_LEN + 1);
  logic [FW-1:0] flt_cnt;

  // Output flips only after FLT_LEN consecutive samples that differ from it.
  always_ff @(posedge i2csf_clk or negedge i2csf_rst_n) begin
    if (!i2csf_rst_n) begin
      flt     <= 1'b1;
      flt_cnt <= FW'(FLT_LEN - 1);
    end else if (sync[1] == flt) begin
      flt_cnt <= FW'(FLT_LEN - 1);
    end else if (flt_cnt == '0) begin
      flt     <= sync[1];
      flt_cnt <= FW'(FLT_LEN - 1);
    end else begin
      flt_cnt <= flt_cnt - 1'b1;
    end
  end
`else
  assign flt = sync[1];
`endif

  always_ff @(posedge i2csf_clk or negedge i2csf_rst_n) begin
    if (!i2csf_rst_n) prev <= 1'b1;
    else              prev <= flt;
  end

  assign lvl  = flt;
  assign rise = flt & ~prev;
  assign fall = ~flt & prev;

endmodule

// File: rtl/i2cs_regif.sv
// I2C slave to single-cycle register access bridge (write burst, read via
// repeated START). Optional input glitch filter: I2CS_GLITCH_FLT_EN.
module i2cs_regif
  import i2cs_pkg::*;
#(
  parameter logic [6:0] DEV_ID  = DEV_ID_DEF,
  parameter int         FLT_LEN = 3
) (
  input  logic       i2csf_clk,
  input  logic       i2csf_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       o_busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2cs_line_cond #(.FLT_LEN(FLT_LEN)) u_scl (
    .i2csf_clk(i2csf_clk), .i2csf_rst_n(i2csf_rst_n), .pad(i_scl),
    .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2cs_line_cond #(.FLT_LEN(FLT_LEN)) u_sda (
    .i2csf_clk(i2csf_clk), .i2csf_rst_n(i2csf_rst_n), .pad(i_sda),
    .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_c, stop_c;
  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       sr;
  logic             ack_go;  // 0: waiting for the fall that opens the ACK slot
  logic             rw;
  logic             mack;
  logic [7:0]       byte_in;

  assign byte_in = {sr[6:0], sda_lvl};

  always_ff @(posedge i2csf_clk or negedge i2csf_rst_n) begin
    if (!i2csf_rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      sr        <= 8'h00;
      ack_go    <= 1'b0;
      rw        <= 1'b0;
      mack      <= 1'b1;
      o_sda_oe  <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      o_busy    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (reg_we) reg_addr <= addr_inc(reg_addr);

      if (stop_c) begin
        state    <= ST_IDLE;
        o_sda_oe <= 1'b0;
        o_busy   <= 1'b0;
      end else if (start_c) begin
        state    <= ST_DEV;
        o_sda_oe <= 1'b0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          ST_DEV, ST_ADDR, ST_WDATA: begin
            if (scl_rise) begin
              sr      <= byte_in;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                ack_go <= 1'b0;
                if (state == ST_DEV) begin
                  if (sr[6:0] == DEV_ID) begin
                    state  <= ST_DEV_ACK;
                    rw     <= sda_lvl;
                    o_busy <= 1'b1;
                  end else begin
                    state <= ST_WAIT_STOP;
                  end
                end else if (state == ST_ADDR) begin
                  reg_addr <= byte_in;
                  state    <= ST_ADDR_ACK;
                end else begin
                  state <= ST_WDATA_ACK;
                end
              end
            end
          end

          ST_DEV_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_go) begin
                ack_go   <= 1'b1;
                o_sda_oe <= 1'b1;
                if (state == ST_WDATA_ACK) begin
                  reg_wdata <= sr;
                  reg_we    <= 1'b1;
                end
              end else begin
                ack_go  <= 1'b0;
                bit_cnt <= '0;
                if (state == ST_DEV_ACK && rw) begin
                  state <= ST_RD_LOAD;  // keep SDA as-is; RD_LOAD drives bit 7
                end else begin
                  o_sda_oe <= 1'b0;
                  state    <= (state == ST_DEV_ACK) ? ST_ADDR : ST_WDATA;
                end
              end
            end
          end

          ST_RD_LOAD: begin
            sr       <= reg_rdata;
            o_sda_oe <= ~reg_rdata[7];
            bit_cnt  <= '0;
            state    <= ST_RDATA;
          end

          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                state  <= ST_RD_MACK;
                ack_go <= 1'b0;
              end
            end else if (scl_fall) begin
              sr       <= {sr[6:0], 1'b0};
              o_sda_oe <= ~sr[6];
            end
          end

          ST_RD_MACK: begin
            if (scl_fall) begin
              if (!ack_go) begin
                ack_go   <= 1'b1;
                o_sda_oe <= 1'b0;
              end else begin
                ack_go <= 1'b0;
                if (!mack) begin
                  reg_addr <= addr_inc(reg_addr);
                  state    <= ST_RD_LOAD;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end else if (scl_rise && ack_go) begin
              mack <= sda_lvl;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2cs_regif.sv
// Self-checking bench for i2cs_regif: directed bus scenarios plus randomized
// write/read/foreign-ID transactions against a transaction-level model.
module tb_i2cs_regif;

  localparam int Q = 10;  // clocks per quarter SCL period (SCL = 40 clocks)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       o_sda_oe, reg_we, o_busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~o_sda_oe;
  assign reg_rdata = reg_addr ^ 8'hFF;

  i2cs_regif dut (
    .i2csf_clk(clk), .i2csf_rst_n(rst_n), .i_scl(scl), .i_sda(sda_line),
    .o_sda_oe(o_sda_oe), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .o_busy(o_busy)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] wr_q[$];
  logic        oe_seen = 1'b0;
  logic        we_prev = 1'b0;
  int          we_wide = 0;

  always @(negedge clk) begin
    if (reg_we) wr_q.push_back({reg_addr, reg_wdata});
    if (reg_we && we_prev) we_wide++;
    we_prev = reg_we;
    if (o_sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(Q); scl = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(Q); scl = 1'b1; wq(Q); sda_m = 1'b1; wq(Q);
  endtask

  // gk: 0 none, 1 short SCL low glitch while high, 2 short SDA low glitch while high
  task automatic xfer_bit(input logic b, input int gk, output logic s);
    sda_m = b; wq(Q); scl = 1'b1; wq(Q / 2);
    if (gk == 1) begin scl = 1'b0; wq(2); scl = 1'b1; end
    if (gk == 2) begin sda_m = 1'b0; wq(2); sda_m = b; end
    wq(Q / 2); s = sda_line; wq(Q); scl = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, input int gk, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) xfer_bit(b[7-i], (i == gbit) ? gk : 0, s);
    xfer_bit(1'b1, 0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin xfer_bit(1'b1, 0, s); b = {b[6:0], s}; end
    xfer_bit(mack, 0, s);
  endtask

  // Compare captured writes against expected (addr,data) list, then empty it.
  task automatic check_writes(input string tag, input logic [15:0] exp[$]);
    check({tag, "_wr_count"}, wr_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_q.size(); i++)
      check({tag, "_wr_entry"}, wr_q[i], exp[i]);
    wr_q.delete();
  endtask

  logic        ack;
  logic [7:0]  rb;
  logic [7:0]  model_addr;
  logic [15:0] exp_q[$];
  logic [7:0]  data[4];

  initial begin
    wq(5);
    check("rst_oe", o_sda_oe, 0);
    check("rst_we", reg_we, 0);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_busy", o_busy, 0);
    rst_n = 1'b1;
    wq(10);
    model_addr = 8'h00;

    // single write
    i2c_start();
    write_byte(8'h78, -1, 0, ack); check("sw_ack_dev", ack, 1);
    check("sw_busy", o_busy, 1);
    write_byte(8'h10, -1, 0, ack); check("sw_ack_addr", ack, 1);
    write_byte(8'hA5, -1, 0, ack); check("sw_ack_data", ack, 1);
    i2c_stop(); wq(Q);
    exp_q = {16'h10A5};
    check_writes("sw", exp_q);
    check("sw_addr", reg_addr, 8'h11);
    check("sw_busy_end", o_busy, 0);

    // burst write
    i2c_start();
    write_byte(8'h78, -1, 0, ack); write_byte(8'h10, -1, 0, ack);
    for (int i = 1; i <= 3; i++) write_byte(8'(i), -1, 0, ack);
    i2c_stop(); wq(Q);
    exp_q = {16'h1001, 16'h1102, 16'h1203};
    check_writes("bw", exp_q);
    check("bw_addr", reg_addr, 8'h13);

    // repeated-start read at 0x20
    i2c_start();
    write_byte(8'h78, -1, 0, ack); write_byte(8'h20, -1, 0, ack);
    i2c_start();
    write_byte(8'h79, -1, 0, ack); check("rd_ack_dev", ack, 1);
    read_byte(1'b0, rb); check("rd_byte0", rb, 8'hDF);
    read_byte(1'b1, rb); check("rd_byte1", rb, 8'hDE);
    check("rd_released", o_sda_oe, 0);
    i2c_stop(); wq(Q);
    exp_q = {};
    check_writes("rd", exp_q);
    check("rd_addr", reg_addr, 8'h21);

    // wrong ID
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h50, -1, 0, ack); check("wid_nack", ack, 0);
    check("wid_busy", o_busy, 0);
    i2c_stop(); wq(Q);
    check("wid_oe_seen", oe_seen, 0);
    check_writes("wid", exp_q);

    // abort after 4 bits of data
    i2c_start();
    write_byte(8'h78, -1, 0, ack); write_byte(8'h30, -1, 0, ack);
    for (int i = 0; i < 4; i++) xfer_bit(i[0], 0, ack);
    i2c_stop(); wq(Q);
    check_writes("abort", exp_q);
    check("abort_addr", reg_addr, 8'h30);
    check("abort_busy", o_busy, 0);
    check("abort_oe", o_sda_oe, 0);

    // wrap at 0xFF
    i2c_start();
    write_byte(8'h78, -1, 0, ack); write_byte(8'hFF, -1, 0, ack);
    write_byte(8'h11, -1, 0, ack); write_byte(8'h22, -1, 0, ack);
    i2c_stop(); wq(Q);
    exp_q = {16'hFF11, 16'h0022};
    check_writes("wrap", exp_q);
    check("wrap_addr", reg_addr, 8'h01);
    model_addr = 8'h01;

`ifdef I2CS_GLITCH_FLT_EN
    i2c_start();
    write_byte(8'h78, -1, 0, ack);
    write_byte(8'h5A, 0, 1, ack); check("flt_scl_ack", ack, 1);
    write_byte(8'h3C, 2, 2, ack); check("flt_sda_ack", ack, 1);
    i2c_stop(); wq(Q);
    exp_q = {16'h5A3C};
    check_writes("flt", exp_q);
    model_addr = 8'h5B;
`endif

    // randomized transactions against the transaction-level model
    for (int it = 0; it < 8; it++) begin
      int kind, n;
      logic [7:0] a;
      kind = $urandom_range(0, 2);
      a    = 8'($urandom_range(0, 255));
      n    = $urandom_range(1, 4);
      exp_q = {};
      oe_seen = 1'b0;
      i2c_start();
      if (kind == 0) begin
        write_byte(8'h78, -1, 0, ack); write_byte(a, -1, 0, ack);
        for (int i = 0; i < n; i++) begin
          data[i] = 8'($urandom_range(0, 255));
          write_byte(data[i], -1, 0, ack);
          check("rnd_wr_ack", ack, 1);
          exp_q.push_back({8'(a + 8'(i)), data[i]});
        end
        model_addr = 8'(a + 8'(n));
      end else if (kind == 1) begin
        write_byte(8'h78, -1, 0, ack); write_byte(a, -1, 0, ack);
        i2c_start();
        write_byte(8'h79, -1, 0, ack);
        for (int i = 0; i < n; i++) begin
          read_byte((i == n - 1), rb);
          check("rnd_rd_byte", rb, 8'(a + 8'(i)) ^ 8'hFF);
        end
        model_addr = 8'(a + 8'(n - 1));
      end else begin
        logic [6:0] id;
        id = 7'($urandom_range(0, 127));
        if (id == 7'h3C) id = 7'h3D;
        write_byte({id, 1'($urandom_range(0, 1))}, -1, 0, ack);
        check("rnd_wid_nack", ack, 0);
      end
      i2c_stop(); wq(Q);
      check_writes("rnd", exp_q);
      check("rnd_addr", reg_addr, model_addr);
      check("rnd_busy", o_busy, 0);
      if (kind == 2) check("rnd_wid_oe", oe_seen, 0);
    end

    check("we_width", we_wide, 0);

    // asynchronous reset while the slave is driving ACK
    i2c_start();
    for (int i = 0; i < 8; i++) xfer_bit(((8'h78 >> (7 - i)) & 8'h1) != 0, 0, ack);
    check("rstmid_pre_oe", o_sda_oe, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_oe", o_sda_oe, 0);
    check("rstmid_busy", o_busy, 0);
    check("rstmid_addr", reg_addr, 8'h00);
    sda_m = 1'b1; scl = 1'b1;
    wq(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
